// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the two-master Wishbone arbiter.
package wb_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 24;
  localparam logic [7:0]  TIMEOUT_DEF    = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts enabled cycles and pulses expire when the count hits a non-zero limit.
module wb_watchdog (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] limit_i,
  output logic       expire_o
);

  logic [7:0] count;

  assign expire_o = (limit_i != 8'd0) && (count == limit_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= 8'd0;
    end else if (clr_i || expire_o) begin
      count <= 8'd0;
    end else if (en_i && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter with bus lock, alternating tie-break and a stall watchdog.
module wb_master_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter logic [7:0]  TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [7:0]            m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [7:0]            m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [7:0]            s_dat_i,
  output logic [1:0]            grant_o
);

  arb_state_e state;
  logic       last_grant;
  logic       own0, own1;
  logic       own_cyc, own_stb, own_we;
  logic       stb_raw, term, leaving;
  logic       wd_hit, wd_err;

  // last_grant holds the index of the master that most recently released the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) state <= last_grant ? GRANT0 : GRANT1;
          else if (m0_cyc_i)        state <= GRANT0;
          else if (m1_cyc_i)        state <= GRANT1;
        end
        GRANT0: begin
          if (!m0_cyc_i) begin
            last_grant <= 1'b0;
            state      <= m1_cyc_i ? GRANT1 : IDLE;
          end
        end
        GRANT1: begin
          if (!m1_cyc_i) begin
            last_grant <= 1'b1;
            state      <= m0_cyc_i ? GRANT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign own0    = (state == GRANT0);
  assign own1    = (state == GRANT1);
  assign grant_o = {own1, own0};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    s_adr_o = '0;
    s_dat_o = 8'h00;
    if (own0) begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
      own_we  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
      own_we  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign stb_raw = own_cyc & own_stb;
  assign term    = s_ack_i | s_err_i | s_rty_i;
  assign leaving = (own0 & ~m0_cyc_i) | (own1 & ~m1_cyc_i);

  wb_watchdog u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (stb_raw),
    .clr_i    (term | ~stb_raw | leaving),
    .limit_i  (TIMEOUT),
    .expire_o (wd_hit)
  );

  // A real slave termination in the expiry cycle takes precedence over the timeout error.
  assign wd_err  = wd_hit & stb_raw & ~term;

  assign s_cyc_o = own_cyc;
  assign s_stb_o = stb_raw & ~wd_err;
  assign s_we_o  = own_cyc & own_we;

  // Terminations are gated by the owner's cyc so a late ack after an abort is dropped.
  assign m0_ack_o = own0 & m0_cyc_i & s_ack_i;
  assign m0_err_o = own0 & m0_cyc_i & (s_err_i | wd_err);
  assign m0_rty_o = own0 & m0_cyc_i & s_rty_i;
  assign m0_dat_o = own0 ? s_dat_i : 8'h00;

  assign m1_ack_o = own1 & m1_cyc_i & s_ack_i;
  assign m1_err_o = own1 & m1_cyc_i & (s_err_i | wd_err);
  assign m1_rty_o = own1 & m1_cyc_i & s_rty_i;
  assign m1_dat_o = own1 ? s_dat_i : 8'h00;

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 ADDR_WIDTH, 24, address width of all master and slave ports.
REQ-002 TIMEOUT, 8'd255, cycles of unanswered slave strobe before a bus error is returned; 0 disables the watchdog.
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 mN_cyc_i, mN_stb_i, mN_we_i (N=0,1)  in  1 each  Wishbone master N cycle, strobe and write-enable; m0 is the host loader, m1 is the Levenshtein engine.
REQ-006 mN_adr_i  in  ADDR_WIDTH  master N address.
REQ-007 mN_dat_i  in  8  master N write data.
REQ-008 mN_ack_o, mN_err_o, mN_rty_o  out  1 each  master N terminations.
REQ-009 mN_dat_o  out  8  master N read data.
REQ-010 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared slave port controls.
REQ-011 s_adr_o  out  ADDR_WIDTH  slave address.
REQ-012 s_dat_o  out  8  slave write data.
REQ-013 s_ack_i, s_err_i, s_rty_i  in  1 each  slave terminations.
REQ-014 s_dat_i  in  8  slave read data.
REQ-015 grant_o  out  2  one-hot current owner (bit N = master N); 2'b00 when idle.

Function
REQ-016 States: IDLE, GRANT0, GRANT1, held in a registered state variable; grant_o decodes it.
REQ-017 IDLE: no request -> stay; one mN_cyc_i high -> GRANTN next cycle; both high -> grant the master not granted last (last_grant register, reset value 1, so m0 wins the first tie).
REQ-018 GRANTN: stay while mN_cyc_i is high, so the owner keeps the bus across any number of strobes (bus lock).
REQ-019 GRANTN with mN_cyc_i low: other master requesting -> GRANT(other) next cycle, else IDLE; last_grant <= N on every exit from GRANTN.
REQ-020 Arbitration latency: exactly one clock from first mN_cyc_i to grant; no cycle where both masters are granted.
REQ-021 When granted: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o combinationally follow the owner; owner sees s_ack_i/s_err_i/s_rty_i and s_dat_i combinationally.
REQ-022 Non-owner: ack/err/rty outputs forced 0, dat_o forced 8'h00, its cycle stalled until granted.
REQ-023 IDLE: s_cyc_o, s_stb_o, s_we_o = 0; s_adr_o, s_dat_o = 0.
REQ-024 Watchdog: 8-bit counter increments each cycle s_stb_o=1 and no slave termination; clears on any termination, on grant change and when s_stb_o=0.
REQ-025 Counter reaching TIMEOUT (TIMEOUT!=0): owner gets mN_err_o=1 for exactly one cycle, s_stb_o masked to 0 that cycle, counter clears.
REQ-026 Slave termination in the same cycle as timeout: slave termination wins, no error generated.
REQ-027 Owner dropping mN_cyc_i mid-transfer: slave controls drop combinationally the same cycle; late slave ack is discarded.
REQ-028 Termination signals from slave at most one owner per cycle; ack, err and rty passed through unmodified (no priority reordering).

Reset
REQ-029 rst_i high forces state IDLE, last_grant=1, watchdog=0 immediately without waiting for clk_i, so all slave controls, all master terminations and grant_o are 0 during reset.
REQ-030 Reset asserted mid-transfer aborts it; after release the arbiter restarts from IDLE and re-arbitrates pending requests per REQ-017.

Structure
REQ-031 Shared package wb_arbiter_pkg holds the state enum (IDLE, GRANT0, GRANT1) and default ADDR_WIDTH/TIMEOUT constants.
REQ-032 The watchdog is a natural sub-module, wb_watchdog (count enable, clear, limit in; expire pulse out); the arbiter FSM stays in the top.

Verification
REQ-033 Only m1 requests, slave acks in 2 cycles, reads 8'hA5 at 0x800010 -> grant_o=2'b10 one cycle after m1_cyc_i, m1_dat_o=8'hA5 with m1_ack_o, m0_ack_o stays 0.
REQ-034 m0 and m1 raise cyc in the same cycle after reset -> m0 granted; m0 drops cyc while m1 holds -> grant_o=2'b10 next cycle; next tie -> m0 granted.
REQ-035 m1 holds cyc over 3 back-to-back strobes while m0 requests -> no grant switch until m1_cyc_i falls.
REQ-036 TIMEOUT=4, slave never acks -> m_err_o pulses for exactly 1 cycle after 4 stalled strobe cycles, s_stb_o=0 that cycle.
REQ-037 TIMEOUT=4, slave acks in the 4th stall cycle -> ack delivered, no err pulse.
REQ-038 rst_i asserted between clock edges mid-transfer -> s_cyc_o and grant_o go 0 before next edge; pending m1 request granted one cycle after release.
